inst_sequencer: RTL and testbench
=================================

INST_SEQUENCER -- requirements
Module: inst_sequencer

Interface
REQ-001 SHALL have parameter inst_bw, default 57, instruction vector width.
REQ-002 SHALL have parameter ADDR_W, default 11, SRAM address width.
REQ-003 SHALL have parameter row, default 8, weight rows loaded per pass.
REQ-004 SHALL have parameter len_nij, default 36, activation vectors per pass.
REQ-005 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-006 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-007 SHALL have port start  input  1  one-cycle request to run one weight-stationary pass.
REQ-008 SHALL have port w_base  input  ADDR_W  x-mem base address of weights, sampled at accepted start.
REQ-009 SHALL have port x_base  input  ADDR_W  x-mem base address of activations, sampled at accepted start.
REQ-010 SHALL have port p_base  input  ADDR_W  psum-mem base address for results, sampled at accepted start.
REQ-011 SHALL have port ofifo_valid  input  1  output FIFO holds a readable row.
REQ-012 SHALL have port inst  output  inst_bw  registered instruction vector driven into core.
REQ-013 SHALL have port busy  output  1  high in every state except IDLE.
REQ-014 SHALL have port done  output  1  one-cycle pulse at pass completion.
REQ-015 SHALL have port error  output  1  sticky drain-timeout flag, cleared by next accepted start.

Function
REQ-016 Field map: os_or_ws[38]=0, sfu_relu[37]=0, sfu_acc[36]=0, ld_mode[35], CEN_pmem[32], WEN_pmem[31], A_pmem[30:20], CEN_xmem[19], WEN_xmem[18], A_xmem[17:7], ofifo_rd[6], ififo_wr[5], ififo_rd[4], l0_rd[3], l0_wr[2], execute[1], kflush[0].
REQ-017 Idle vector: CEN_pmem=1, WEN_pmem=1, CEN_xmem=1, WEN_xmem=1, bit 40=1, all other bits 0.
REQ-018 States: IDLE, WRD, KLOAD, ARD, AEXEC, DRAIN, FIN; start accepted only in IDLE, ignored otherwise.
REQ-019 WRD, row cycles: CEN_xmem=0, WEN_xmem=1, A_xmem=w_base+k (k=0..row-1); l0_wr=1 one cycle after each read (1-cycle SRAM latency), so l0_wr high for row cycles starting cycle 2 of WRD.
REQ-020 KLOAD, row cycles: ld_mode=1, l0_rd=1, execute=0; kflush=1 on first KLOAD cycle only.
REQ-021 ARD, len_nij cycles: same read/l0_wr pattern as WRD at x_base+n; trailing l0_wr cycle overlaps first AEXEC cycle.
REQ-022 AEXEC, len_nij cycles: ld_mode=0, l0_rd=1, execute=1.
REQ-023 DRAIN: ofifo_rd = ofifo_valid while write count < len_nij; cycle after each ofifo_rd, CEN_pmem=0, WEN_pmem=0, A_pmem=p_base+m, m incremented.
REQ-024 After len_nij-th pmem write -> FIN one cycle (done=1, idle vector) -> IDLE.
REQ-025 Address sums wrap modulo 2^ADDR_W.
REQ-026 Counters sized ceil(log2(max(row,len_nij)+1)); no pass shorter than programmed count.
REQ-027 Pass latency with ofifo_valid held high from DRAIN entry: 2*row+2*len_nij+len_nij+3 cycles start-to-done (= 127 at defaults).

Reset
REQ-028 reset asserted: state=IDLE, counters=0, inst=idle vector, busy=0, done=0, error=0, immediately (asynchronous).
REQ-029 reset mid-pass aborts without done pulse; sampled bases discarded.

Configuration
REQ-030 Macro INST_SEQ_DRAIN_TIMEOUT_EN defined: in DRAIN, 255 consecutive cycles with ofifo_valid=0 set error=1, force idle vector, go to IDLE, no done.
REQ-031 Macro undefined: DRAIN waits indefinitely; error tied 0.

Verification
REQ-032 start, w_base=0x010, x_base=0x100, p_base=0x200, ofifo_valid=1 -> A_xmem 0x010..0x017 then 0x100..0x123, A_pmem 0x200..0x223, done at cycle 127.
REQ-033 w_base=0x7FE -> A_xmem sequence 0x7FE,0x7FF,0x000..0x005.
REQ-034 ofifo_valid toggled 1/0 every cycle in DRAIN -> exactly 36 ofifo_rd pulses, 36 pmem writes, contiguous addresses, done once.
REQ-035 start pulsed during AEXEC -> no restart; single done.
REQ-036 reset asserted in ARD -> next cycle inst=idle vector, busy=0, no done.
REQ-037 macro defined, ofifo_valid=0 through DRAIN -> error=1 after 255 cycles, busy=0, done never asserted.

Source files
------------

// File: rtl/inst_sequencer.sv
// Weight-stationary pass sequencer: loads weights, activations and drains results by driving a registered instruction vector.
// Optional drain watchdog enabled by defining INST_SEQ_DRAIN_TIMEOUT_EN.
module inst_sequencer #(
  parameter int inst_bw = 57,
  parameter int ADDR_W  = 11,
  parameter int row     = 8,
  parameter int len_nij = 36
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [ADDR_W-1:0]  w_base,
  input  logic [ADDR_W-1:0]  x_base,
  input  logic [ADDR_W-1:0]  p_base,
  input  logic               ofifo_valid,
  output logic [inst_bw-1:0] inst,
  output logic               busy,
  output logic               done,
  output logic               error
);

  localparam int CNT_MAX = (row > len_nij) ? row : len_nij;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] ROW_LAST = CNT_W'(row - 1);
  localparam logic [CNT_W-1:0] NIJ_LAST = CNT_W'(len_nij - 1);
  localparam logic [CNT_W-1:0] NIJ_CNT  = CNT_W'(len_nij);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [inst_bw-1:0] IDLE_VEC = (inst_bw'(1) << 40) | (inst_bw'(1) << 32) |
                                            (inst_bw'(1) << 31) | (inst_bw'(1) << 19) |
                                            (inst_bw'(1) << 18);

  typedef enum logic [2:0] {
    S_IDLE, S_WRD, S_KLOAD, S_ARD, S_AEXEC, S_DRAIN, S_FIN
  } state_t;

  state_t               r_state;
  state_t               w_next_state;
  logic [ADDR_W-1:0]    r_w_base;
  logic [ADDR_W-1:0]    r_x_base;
  logic [ADDR_W-1:0]    r_p_base;
  logic [CNT_W-1:0]     r_cnt;
  logic [CNT_W-1:0]     r_wcnt;
  logic                 r_rd_pend;
  logic                 r_ofrd_pend;
  logic [inst_bw-1:0]   r_inst;
  logic                 r_done;
  logic [inst_bw-1:0]   w_inst;
  logic                 w_accept;
  logic                 w_ofifo_rd;
  logic                 w_timeout;

  assign w_accept   = (r_state == S_IDLE) && start;
  // In DRAIN r_cnt counts FIFO reads, r_wcnt counts the pmem writes that follow them.
  assign w_ofifo_rd = (r_state == S_DRAIN) && ofifo_valid && (r_cnt < NIJ_CNT);
  assign inst       = r_inst;
  assign busy       = (r_state != S_IDLE);
  assign done       = r_done;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_next_state = S_WRD;
      S_WRD:   if (r_cnt == ROW_LAST) w_next_state = S_KLOAD;
      S_KLOAD: if (r_cnt == ROW_LAST) w_next_state = S_ARD;
      S_ARD:   if (r_cnt == NIJ_LAST) w_next_state = S_AEXEC;
      S_AEXEC: if (r_cnt == NIJ_LAST) w_next_state = S_DRAIN;
      S_DRAIN: begin
        if (w_timeout)                             w_next_state = S_IDLE;
        else if (r_ofrd_pend && r_wcnt == NIJ_LAST) w_next_state = S_FIN;
      end
      S_FIN:   w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // l0_wr trails each SRAM read by one cycle to cover the read latency.
  always_comb begin
    w_inst    = IDLE_VEC;
    w_inst[2] = r_rd_pend;
    case (r_state)
      S_WRD: begin
        w_inst[19]           = 1'b0;
        w_inst[7 +: ADDR_W]  = r_w_base + ADDR_W'(r_cnt);
      end
      S_KLOAD: begin
        w_inst[35] = 1'b1;
        w_inst[3]  = 1'b1;
        w_inst[0]  = (r_cnt == '0);
      end
      S_ARD: begin
        w_inst[19]           = 1'b0;
        w_inst[7 +: ADDR_W]  = r_x_base + ADDR_W'(r_cnt);
      end
      S_AEXEC: begin
        w_inst[3] = 1'b1;
        w_inst[1] = 1'b1;
      end
      S_DRAIN: begin
        w_inst[6] = w_ofifo_rd;
        if (r_ofrd_pend) begin
          w_inst[32]           = 1'b0;
          w_inst[31]           = 1'b0;
          w_inst[20 +: ADDR_W] = r_p_base + ADDR_W'(r_wcnt);
        end
      end
      default: ;
    endcase
    if (w_timeout) w_inst = IDLE_VEC;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_w_base    <= '0;
      r_x_base    <= '0;
      r_p_base    <= '0;
      r_cnt       <= '0;
      r_wcnt      <= '0;
      r_rd_pend   <= 1'b0;
      r_ofrd_pend <= 1'b0;
      r_inst      <= IDLE_VEC;
      r_done      <= 1'b0;
    end else begin
      r_inst      <= w_inst;
      r_done      <= (r_state == S_FIN);
      r_rd_pend   <= (r_state == S_WRD) || (r_state == S_ARD);
      r_ofrd_pend <= w_ofifo_rd;
      if (w_accept) begin
        r_w_base <= w_base;
        r_x_base <= x_base;
        r_p_base <= p_base;
      end
      if (w_next_state != r_state) begin
        r_cnt  <= '0;
        r_wcnt <= '0;
      end else if (r_state == S_DRAIN) begin
        r_cnt  <= r_cnt + CNT_W'(w_ofifo_rd);
        r_wcnt <= r_wcnt + CNT_W'(r_ofrd_pend);
      end else if (r_state != S_IDLE) begin
        r_cnt  <= r_cnt + CNT_ONE;
      end
    end
  end

`ifdef INST_SEQ_DRAIN_TIMEOUT_EN
  logic [7:0] r_to_cnt;
  logic       r_error;

  // Fires on the 255th consecutive DRAIN cycle without ofifo_valid.
  assign w_timeout = (r_state == S_DRAIN) && !ofifo_valid && (r_to_cnt == 8'd254);
  assign error     = r_error;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_to_cnt <= '0;
      r_error  <= 1'b0;
    end else begin
      if (r_state == S_DRAIN && !ofifo_valid) r_to_cnt <= r_to_cnt + 8'd1;
      else                                    r_to_cnt <= '0;
      if (w_accept)       r_error <= 1'b0;
      else if (w_timeout) r_error <= 1'b1;
    end
  end
`else
  assign w_timeout = 1'b0;
  assign error     = 1'b0;
`endif

endmodule

// File: tb/tb_inst_sequencer.sv
// Directed bench for inst_sequencer: address sequences, wrap, drain backpressure, restart guard, reset abort.
// Latency n counts rising edges from the one sampling start up to the one after which done is seen.
module tb_inst_sequencer;
  localparam int IBW = 57;
  localparam int AW  = 11;
  localparam int ROW = 8;
  localparam int NIJ = 36;

  logic           clk = 1'b0;
  logic           reset;
  logic           start;
  logic [AW-1:0]  w_base;
  logic [AW-1:0]  x_base;
  logic [AW-1:0]  p_base;
  logic           ofifo_valid;
  logic [IBW-1:0] inst;
  logic           busy;
  logic           done;
  logic           error;
  logic [IBW-1:0] idle_vec;

  int checks   = 0;
  int failures = 0;

  inst_sequencer #(.inst_bw(IBW), .ADDR_W(AW), .row(ROW), .len_nij(NIJ)) dut (
    .clk(clk), .reset(reset), .start(start), .w_base(w_base), .x_base(x_base),
    .p_base(p_base), .ofifo_valid(ofifo_valid), .inst(inst), .busy(busy),
    .done(done), .error(error)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // mode: 0 = ofifo_valid held high, 1 = toggled every cycle, 2 = held low
  task automatic run_pass(input logic [AW-1:0] wb, input logic [AW-1:0] xb,
                          input logic [AW-1:0] pb, input int mode,
                          input bit poke, input bit check_lat);
    logic [AW-1:0] exp_q[$];
    logic [AW-1:0] got_x[$];
    logic [AW-1:0] got_p[$];
    int n = 0, done_n = 0, done_cnt = 0, rd_cnt = 0, l0wr_cnt = 0;
    int kf_cnt = 0, ex_cnt = 0, ld_cnt = 0, first_rd = 0, first_wr = 0;
    w_base = wb; x_base = xb; p_base = pb;
    ofifo_valid = (mode != 2);
    start = 1'b1;
    while (n < 1000 && (done_n == 0 || n < done_n + 4)) begin
      @(posedge clk); #1; n++;
      if (n == 1) start = 1'b0;
      if (poke && n == 60) start = 1'b1;
      if (poke && n == 61) start = 1'b0;
      if (!inst[19]) begin
        got_x.push_back(inst[17:7]);
        if (first_rd == 0) first_rd = n;
      end
      if (inst[2]) begin
        l0wr_cnt++;
        if (first_wr == 0) first_wr = n;
      end
      if (!inst[32] && !inst[31]) got_p.push_back(inst[30:20]);
      if (inst[6]) rd_cnt++;
      if (inst[0]) kf_cnt++;
      if (inst[1]) ex_cnt++;
      if (inst[35] && inst[3]) ld_cnt++;
      if (done) begin
        done_cnt++;
        if (done_n == 0) done_n = n;
      end
      if (mode == 1) ofifo_valid = ~ofifo_valid;
    end

    for (int k = 0; k < ROW; k++) exp_q.push_back(wb + AW'(k));
    for (int k = 0; k < NIJ; k++) exp_q.push_back(xb + AW'(k));
    check("xmem_reads", 64'(got_x.size()), 64'(ROW + NIJ));
    for (int i = 0; i < ROW + NIJ; i++)
      if (got_x.size() > 0) check($sformatf("xmem_addr%0d", i), 64'(got_x.pop_front()), 64'(exp_q.pop_front()));
    check("l0_wr_cnt", 64'(l0wr_cnt), 64'(ROW + NIJ));
    check("l0_wr_lag", 64'(first_wr - first_rd), 64'(1));
    check("kflush_cnt", 64'(kf_cnt), 64'(1));
    check("kload_cnt", 64'(ld_cnt), 64'(ROW));
    check("exec_cnt", 64'(ex_cnt), 64'(NIJ));
    check("busy_end", 64'(busy), 64'(0));
    exp_q.delete();
    if (mode != 2) begin
      for (int k = 0; k < NIJ; k++) exp_q.push_back(pb + AW'(k));
      check("ofifo_rd_cnt", 64'(rd_cnt), 64'(NIJ));
      check("pmem_writes", 64'(got_p.size()), 64'(NIJ));
      for (int i = 0; i < NIJ; i++)
        if (got_p.size() > 0) check($sformatf("pmem_addr%0d", i), 64'(got_p.pop_front()), 64'(exp_q.pop_front()));
      check("done_cnt", 64'(done_cnt), 64'(1));
      check("error_clr", 64'(error), 64'(0));
      if (check_lat) check("latency", 64'(done_n), 64'(2*ROW + 3*NIJ + 3));
    end else begin
      check("to_ofifo_rd", 64'(rd_cnt), 64'(0));
      check("to_pmem", 64'(got_p.size()), 64'(0));
      check("to_done", 64'(done_cnt), 64'(0));
      check("to_error", 64'(error), 64'(1));
      check("to_inst", 64'(inst), 64'(idle_vec));
    end
  endtask

  task automatic reset_in_ard();
    int done_cnt = 0;
    w_base = 11'h055; x_base = 11'h155; p_base = 11'h255;
    ofifo_valid = 1'b1;
    start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (29) @(posedge clk);
    #2;
    check("pre_rst_busy", 64'(busy), 64'(1));
    reset = 1'b1;
    #1;
    check("rst_inst", 64'(inst), 64'(idle_vec));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_done", 64'(done), 64'(0));
    @(posedge clk); #1; reset = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #1;
      if (done) done_cnt++;
    end
    check("rst_no_done", 64'(done_cnt), 64'(0));
    check("rst_idle_inst", 64'(inst), 64'(idle_vec));
  endtask

  initial begin
    idle_vec = '0;
    idle_vec[40] = 1'b1; idle_vec[32] = 1'b1; idle_vec[31] = 1'b1;
    idle_vec[19] = 1'b1; idle_vec[18] = 1'b1;
    reset = 1'b1; start = 1'b0; ofifo_valid = 1'b0;
    w_base = '0; x_base = '0; p_base = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_inst", 64'(inst), 64'(idle_vec));
    check("reset_busy", 64'(busy), 64'(0));
    check("reset_done", 64'(done), 64'(0));
    check("reset_error", 64'(error), 64'(0));
    reset = 1'b0;
    @(posedge clk); #1;

    run_pass(11'h010, 11'h100, 11'h200, 0, 1'b0, 1'b1);
    run_pass(11'h7FE, 11'h7F0, 11'h7F0, 0, 1'b0, 1'b1);
    run_pass(11'h123, 11'h045, 11'h300, 1, 1'b0, 1'b0);
    run_pass(11'h010, 11'h100, 11'h200, 0, 1'b1, 1'b1);
    reset_in_ard();
`ifdef INST_SEQ_DRAIN_TIMEOUT_EN
    run_pass(11'h020, 11'h120, 11'h220, 2, 1'b0, 1'b0);
    run_pass(11'h030, 11'h130, 11'h230, 0, 1'b0, 1'b1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
